// File: rtl/noc_link_arbiter.sv
// noc_link_arbiter: multiplexes the NoC boundary output channels onto one
// off-chip valid/ready link. Each channel has a small FIFO sized to the
// router's credit count; a round-robin arbiter drains the FIFOs into a
// single output register and returns one credit per flit it pops.
module noc_link_arbiter #(
    parameter int FW  = 36,
    parameter int B   = 4,
    parameter int NCH = 8,
    parameter int CW  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FW*NCH-1:0]   flit_in,
    input  logic [NCH-1:0]      flit_in_wr,
    output logic [NCH-1:0]      credit_out,
    output logic                link_valid,
    input  logic                link_ready,
    output logic [CW+FW-1:0]    link_data,
    output logic [NCH-1:0]      link_chan_busy,
    output logic                ovf_err
);

    localparam int PW   = (B > 1) ? $clog2(B) : 1;
    localparam int CNTW = $clog2(B + 1);

    logic [FW-1:0]   mem    [NCH][B];
    logic [PW-1:0]   wr_ptr [NCH];
    logic [PW-1:0]   rd_ptr [NCH];
    logic [CNTW-1:0] count  [NCH];

    logic [NCH-1:0]  non_empty;
    logic [NCH-1:0]  full;
    logic [NCH-1:0]  push;
    logic [NCH-1:0]  pop;
    logic [CW-1:0]   rr_ptr;
    logic [CW-1:0]   grant_idx;
    logic            grant_valid;
    logic            load_en;
    logic [FW-1:0]   head_flit;

    // The output register can take a new flit when it is empty or being drained.
    assign load_en = !link_valid || link_ready;

    assign head_flit      = mem[grant_idx][rd_ptr[grant_idx]];
    assign link_chan_busy = non_empty;

    // Per-channel occupancy flags and the accepted-write mask; a full FIFO still
    // accepts a write when its head leaves in the same cycle.
    always_comb begin
        non_empty = '0;
        full      = '0;
        push      = '0;
        for (int c = 0; c < NCH; c++) begin
            non_empty[c] = (count[c] != '0);
            full[c]      = (count[c] == CNTW'(B));
            push[c]      = flit_in_wr[c] && (!full[c] || pop[c]);
        end
    end

    // Round-robin search: first non-empty channel at or above the pointer, wrapping.
    always_comb begin
        int          cand;
        logic [CW-1:0] cand_idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < NCH; i++) begin
            cand     = (int'(rr_ptr) + i) % NCH;
            cand_idx = CW'(cand);
            if (!grant_valid && non_empty[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // One-hot pop of the granted channel whenever the output register loads.
    always_comb begin
        pop = '0;
        if (load_en && grant_valid) begin
            pop[grant_idx] = 1'b1;
        end
    end

    // FIFO pointers and occupancy; reset empties every channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (push[c]) begin
                    wr_ptr[c] <= (wr_ptr[c] == PW'(B - 1)) ? '0 : wr_ptr[c] + PW'(1);
                end
                if (pop[c]) begin
                    rd_ptr[c] <= (rd_ptr[c] == PW'(B - 1)) ? '0 : rd_ptr[c] + PW'(1);
                end
                if (push[c] && !pop[c]) begin
                    count[c] <= count[c] + CNTW'(1);
                end else if (!push[c] && pop[c]) begin
                    count[c] <= count[c] - CNTW'(1);
                end
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c]] <= flit_in[FW*c +: FW];
            end
        end
    end

    // Sticky overflow flag: a write hit a full FIFO that was not draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err <= 1'b0;
        end else if (|(flit_in_wr & full & ~pop)) begin
            ovf_err <= 1'b1;
        end
    end

    // Round-robin pointer moves just past the channel that was granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (load_en && grant_valid) begin
            rr_ptr <= (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + CW'(1);
        end
    end

    // Link output register, tagged with the granted channel index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_valid <= 1'b0;
            link_data  <= '0;
        end else if (load_en) begin
            link_valid <= grant_valid;
            link_data  <= grant_valid ? {grant_idx, head_flit} : '0;
        end
    end

    // Credit pulses follow each pop by one cycle, one per flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_out <= '0;
        end else begin
            credit_out <= pop;
        end
    end

endmodule

// File: tb/tb_noc_link_arbiter.sv
// Testbench for noc_link_arbiter: table-driven single-flit latency vectors,
// hand-written round-robin / backpressure / overflow / reset sequences, and a
// scoreboard queue that checks every flit leaving on the link.
module tb_noc_link_arbiter;

    localparam int FW  = 36;
    localparam int B   = 4;
    localparam int NCH = 8;
    localparam int CW  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [FW*NCH-1:0]   flit_in;
    logic [NCH-1:0]      flit_in_wr;
    logic [NCH-1:0]      credit_out;
    logic                link_valid;
    logic                link_ready;
    logic [CW+FW-1:0]    link_data;
    logic [NCH-1:0]      link_chan_busy;
    logic                ovf_err;

    typedef struct {
        int               chan;
        logic [FW-1:0]    flit;
        logic [CW+FW-1:0] exp_data;
        logic [NCH-1:0]   exp_credit;
    } vec_t;

    vec_t             vecs [4];
    logic [CW+FW-1:0] sb [$];
    int               checks = 0;
    int               errors = 0;
    int               credit_cnt [NCH];

    noc_link_arbiter #(.FW(FW), .B(B), .NCH(NCH), .CW(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .flit_in        (flit_in),
        .flit_in_wr     (flit_in_wr),
        .credit_out     (credit_out),
        .link_valid     (link_valid),
        .link_ready     (link_ready),
        .link_data      (link_data),
        .link_chan_busy (link_chan_busy),
        .ovf_err        (ovf_err)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one write cycle: every channel in mask receives the same flit.
    task automatic applyStimulus(input logic [NCH-1:0] mask, input logic [FW-1:0] data);
        flit_in    = {NCH{data}};
        flit_in_wr = mask;
        step();
        flit_in_wr = '0;
    endtask

    function automatic logic [CW+FW-1:0] linkWord(input int c, input logic [FW-1:0] f);
        return {CW'(c), f};
    endfunction

    task automatic clearCredits();
        for (int c = 0; c < NCH; c++) credit_cnt[c] = 0;
    endtask

    // Observes the link on the falling edge: counts credits and pops the
    // scoreboard for every flit the link accepts.
    task automatic monitor();
        logic [CW+FW-1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int c = 0; c < NCH; c++) begin
                    if (credit_out[c]) credit_cnt[c]++;
                end
                if (link_valid && link_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_flit: got %0h, expected no flit", link_data);
                    end else begin
                        exp = sb.pop_front();
                        checkOutput("link_word", 64'(link_data), 64'(exp));
                    end
                end
            end
        end
    endtask

    task automatic drainWait(input string name, input int max_cycles);
        int n = 0;
        while ((sb.size() != 0 || link_valid) && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0 || link_valid) begin
            errors++;
            $display("[TB] FAIL %s: got %0d flits still pending, expected 0 within %0d cycles",
                     name, sb.size(), max_cycles);
        end
    endtask

    // Hard stop in case a sequence never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        logic [NCH-1:0] m;
        rst        = 1'b1;
        flit_in    = '0;
        flit_in_wr = '0;
        link_ready = 1'b0;
        clearCredits();
        fork
            monitor();
        join_none

        // Reset state.
        step();
        checkOutput("rst_valid",  64'(link_valid),     64'(0));
        checkOutput("rst_data",   64'(link_data),      64'(0));
        checkOutput("rst_credit", 64'(credit_out),     64'(0));
        checkOutput("rst_busy",   64'(link_chan_busy), 64'(0));
        checkOutput("rst_ovf",    64'(ovf_err),        64'(0));
        step();
        rst = 1'b0;
        $display("[TB] reset released");

        // Single-flit latency table; last entry on channel 7 leaves the pointer at 0.
        vecs[0] = '{5, 36'h123456789, 39'h5123456789, 8'h20};
        vecs[1] = '{0, 36'hFFFFFFFFF, 39'h0FFFFFFFFF, 8'h01};
        vecs[2] = '{3, 36'hABCDE0123, 39'h3ABCDE0123, 8'h08};
        vecs[3] = '{7, 36'h000000000, 39'h7000000000, 8'h80};
        link_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m = '0;
            m[vecs[i].chan] = 1'b1;
            sb.push_back(vecs[i].exp_data);
            applyStimulus(m, vecs[i].flit);
            checkOutput("tbl_busy",    64'(link_chan_busy), 64'(m));
            checkOutput("tbl_early",   64'(link_valid),     64'(0));
            step();
            checkOutput("tbl_valid",   64'(link_valid),     64'(1));
            checkOutput("tbl_data",    64'(link_data),      64'(vecs[i].exp_data));
            checkOutput("tbl_credit",  64'(credit_out),     64'(vecs[i].exp_credit));
            step();
            checkOutput("tbl_idle",    64'(link_valid),     64'(0));
            checkOutput("tbl_nocred",  64'(credit_out),     64'(0));
        end
        checkOutput("tbl_ptr", 64'(dut.rr_ptr), 64'(0));

        // Round-robin: channels 0, 3, 7 preloaded in one cycle.
        $display("[TB] round-robin");
        link_ready = 1'b0;
        sb.push_back(linkWord(0, 36'hA00000001));
        sb.push_back(linkWord(3, 36'hA00000001));
        sb.push_back(linkWord(7, 36'hA00000001));
        applyStimulus(8'h89, 36'hA00000001);
        checkOutput("rr_busy", 64'(link_chan_busy), 64'(8'h89));
        step();
        checkOutput("rr_first", 64'(link_data), 64'(linkWord(0, 36'hA00000001)));
        checkOutput("rr_ptr1",  64'(dut.rr_ptr), 64'(1));
        link_ready = 1'b1;
        step();
        checkOutput("rr_second", 64'(link_data), 64'(linkWord(3, 36'hA00000001)));
        checkOutput("rr_ptr4",   64'(dut.rr_ptr), 64'(4));
        step();
        checkOutput("rr_third", 64'(link_data), 64'(linkWord(7, 36'hA00000001)));
        checkOutput("rr_ptr0",  64'(dut.rr_ptr), 64'(0));
        step();
        checkOutput("rr_idle", 64'(link_valid), 64'(0));

        // Refill 0 and 7 together: pointer at 0 serves channel 0 first.
        sb.push_back(linkWord(0, 36'hB00000002));
        sb.push_back(linkWord(7, 36'hB00000002));
        applyStimulus(8'h81, 36'hB00000002);
        step();
        checkOutput("rf_first",  64'(link_data),  64'(linkWord(0, 36'hB00000002)));
        checkOutput("rf_ptr1",   64'(dut.rr_ptr), 64'(1));
        step();
        checkOutput("rf_second", 64'(link_data),  64'(linkWord(7, 36'hB00000002)));
        checkOutput("rf_ptr0",   64'(dut.rr_ptr), 64'(0));
        step();
        checkOutput("rf_idle",   64'(link_valid), 64'(0));

        // Backpressure on channel 2: one flit in the register, two buffered.
        $display("[TB] backpressure");
        link_ready = 1'b0;
        clearCredits();
        sb.push_back(linkWord(2, 36'hC0000000A));
        sb.push_back(linkWord(2, 36'hC0000000B));
        sb.push_back(linkWord(2, 36'hC0000000C));
        applyStimulus(8'h04, 36'hC0000000A);
        applyStimulus(8'h04, 36'hC0000000B);
        applyStimulus(8'h04, 36'hC0000000C);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("bp_hold", 64'(link_data), 64'(linkWord(2, 36'hC0000000A)));
        end
        checkOutput("bp_valid",   64'(link_valid),    64'(1));
        checkOutput("bp_credits", 64'(credit_cnt[2]), 64'(1));
        checkOutput("bp_count",   64'(dut.count[2]),  64'(2));
        link_ready = 1'b1;
        step();
        checkOutput("bp_rel1", 64'(link_data), 64'(linkWord(2, 36'hC0000000B)));
        step();
        checkOutput("bp_rel2", 64'(link_data), 64'(linkWord(2, 36'hC0000000C)));
        step();
        checkOutput("bp_idle",     64'(link_valid),    64'(0));
        checkOutput("bp_credits3", 64'(credit_cnt[2]), 64'(3));

        // Overflow: channel 4 parks in the register, then channel 1 fills and overflows.
        $display("[TB] overflow");
        link_ready = 1'b0;
        clearCredits();
        sb.push_back(linkWord(4, 36'hD000000FF));
        for (int k = 0; k < 4; k++) sb.push_back(linkWord(1, 36'hE00000000 + 36'(k)));
        applyStimulus(8'h10, 36'hD000000FF);
        for (int k = 0; k < 4; k++) applyStimulus(8'h02, 36'hE00000000 + 36'(k));
        checkOutput("ovf_count_full", 64'(dut.count[1]), 64'(4));
        checkOutput("ovf_not_yet",    64'(ovf_err),      64'(0));
        checkOutput("ovf_parked",     64'(link_data),    64'(linkWord(4, 36'hD000000FF)));
        applyStimulus(8'h02, 36'hE00000004);
        checkOutput("ovf_set",        64'(ovf_err),      64'(1));
        checkOutput("ovf_count_kept", 64'(dut.count[1]), 64'(4));
        link_ready = 1'b1;
        drainWait("ovf_drain", 20);
        checkOutput("ovf_credits1", 64'(credit_cnt[1]), 64'(4));
        checkOutput("ovf_credits4", 64'(credit_cnt[4]), 64'(1));
        checkOutput("ovf_sticky",   64'(ovf_err),       64'(1));

        // Synchronous-style reset pulse to clear the sticky flag.
        rst = 1'b1;
        step();
        checkOutput("clr_ovf", 64'(ovf_err), 64'(0));
        rst = 1'b0;

        // Push into a full FIFO in the same cycle it pops: accepted, no error.
        $display("[TB] push/pop at full");
        link_ready = 1'b0;
        clearCredits();
        for (int k = 0; k < 6; k++) sb.push_back(linkWord(6, 36'hF00000000 + 36'(k)));
        for (int k = 0; k < 5; k++) applyStimulus(8'h40, 36'hF00000000 + 36'(k));
        checkOutput("pp_count",  64'(dut.count[6]), 64'(4));
        checkOutput("pp_parked", 64'(link_data),    64'(linkWord(6, 36'hF00000000)));
        link_ready = 1'b1;
        applyStimulus(8'h40, 36'hF00000005);
        checkOutput("pp_no_ovf", 64'(ovf_err),      64'(0));
        checkOutput("pp_count2", 64'(dut.count[6]), 64'(4));
        checkOutput("pp_next",   64'(link_data),    64'(linkWord(6, 36'hF00000001)));
        drainWait("pp_drain", 20);
        checkOutput("pp_credits", 64'(credit_cnt[6]), 64'(6));
        checkOutput("pp_no_ovf2", 64'(ovf_err),       64'(0));

        // Asynchronous reset between edges while a flit is pending.
        $display("[TB] async reset");
        link_ready = 1'b0;
        applyStimulus(8'h08, 36'h111111111);
        applyStimulus(8'h08, 36'h222222222);
        checkOutput("ar_valid_pre",  64'(link_valid),     64'(1));
        checkOutput("ar_credit_pre", 64'(credit_out),     64'(8'h08));
        checkOutput("ar_busy_pre",   64'(link_chan_busy), 64'(8'h08));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_valid",  64'(link_valid),     64'(0));
        checkOutput("ar_credit", 64'(credit_out),     64'(0));
        checkOutput("ar_busy",   64'(link_chan_busy), 64'(0));
        checkOutput("ar_data",   64'(link_data),      64'(0));
        step();
        rst = 1'b0;
        checkOutput("ar_ptr", 64'(dut.rr_ptr), 64'(0));
        link_ready = 1'b1;
        sb.push_back(linkWord(5, 36'h0CAFEF00D));
        applyStimulus(8'h20, 36'h0CAFEF00D);
        checkOutput("ar_lat1", 64'(link_valid), 64'(0));
        step();
        checkOutput("ar_lat2",   64'(link_valid), 64'(1));
        checkOutput("ar_data2",  64'(link_data),  64'(linkWord(5, 36'h0CAFEF00D)));
        checkOutput("ar_credit2", 64'(credit_out), 64'(8'h20));
        step();
        checkOutput("ar_idle",   64'(link_valid), 64'(0));
        checkOutput("ar_ptr6",   64'(dut.rr_ptr), 64'(6));
        checkOutput("sb_empty",  64'(sb.size()),  64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
